counter_seq_checker: RTL and testbench
======================================

Name: counter_seq_checker

Overview:
- Consumer-side monitor for the mod-N counter family. It samples a counter's value bus, locks onto the wrap sequence 0,1,..,MOD-1,0, and flags every departure from it.
- It tracks the expected next value, counts errors, and reports lock status.
- It sits beside a counter instance in lab top-levels and benches as a self-checking observer.

Parameters:
WIDTH, 3, width of the observed value bus
MOD, 7, counter modulus; legal values 0..MOD-1; requires 2 <= MOD <= 2**WIDTH
LOCK_LEN, 4, consecutive correct samples needed to declare lock (>=1)
LOSS_LEN, 3, consecutive error samples in LOCKED that drop lock (>=1)

Ports:
clock  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low; clears all state when 0
sample  input  1  value is checked on a rising clock edge only when 1
value  input  WIDTH  observed counter output
clear_stats  input  1  synchronous clear of err_count
locked  output  1  1 while in LOCKED
mismatch  output  1  one-cycle pulse: an error sample was seen in LOCKED
restart  output  1  one-cycle pulse: value==0 seen out of sequence in LOCKED (counter reset), not an error
expected  output  WIDTH  value predicted for the next sample
err_count  output  8  saturating error count (stops at 255)

Behaviour:
- Interface: one clock; reset is asynchronous and active-low.
- All outputs are registered. Response to a sample is visible the cycle after the sampling edge. Pulses last exactly one cycle.
- Reset values (reset=0, asynchronous):
  - state=HUNT
  - locked=0, mismatch=0, restart=0
  - expected=0, err_count=0
  - internal good_cnt=0, miss_cnt=0
- next(v) = (v==MOD-1) ? 0 : v+1. Any value >= MOD is illegal.
- sample=0: state, expected and counters hold. mismatch and restart are 0.
- States and transitions (all on sampled edges):
  - HUNT:
    - value==0 -> VERIFY, expected=1, good_cnt=1. If LOCK_LEN==1, go directly to LOCKED.
    - Any other value (including illegal) -> stay in HUNT; no error.
  - VERIFY:
    - value==expected -> expected=next(value), good_cnt+1. When good_cnt reaches LOCK_LEN -> LOCKED, locked=1.
    - value==0 out of sequence -> restart verification: expected=1, good_cnt=1.
    - Other mismatch -> HUNT, expected=0, good_cnt=0. Never counts an error.
  - LOCKED:
    - value==expected -> expected=next, miss_cnt=0.
    - value==0 and expected!=0 -> restart pulse, expected=1, miss_cnt=0. Stay LOCKED; no error.
    - Other mismatch (including illegal) -> mismatch pulse, err_count+1 (saturating), miss_cnt+1.
      - Legal value: expected=next(value).
      - Illegal value: expected=next(expected).
    - When miss_cnt reaches LOSS_LEN -> HUNT, locked=0, expected=0, miss_cnt=0, good_cnt=0.
- Wrap: MOD-1 followed by 0 is correct, not a restart.
- clear_stats:
  - Takes precedence over a same-cycle increment: err_count=0 and that error is not counted.
  - The mismatch pulse and state effects of that sample still occur.
  - Works in every state and independent of sample.
- err_count at 255 holds at 255. mismatch pulses still occur.
- Reset mid-operation: all state returns immediately to reset values, with no wait for a clock edge. The first sample after release is handled as HUNT.

Test Plan:
- Reset with reset=0, then release. Feed 0,1,2,3 with sample=1 -> locked rises the cycle after the value-3 edge; expected=4; err_count=0.
- From locked, feed 4,5,6,0,1 -> no mismatch or restart pulses; expected=2 after the last sample; locked stays 1.
- From locked with expected=2, feed 5 -> one-cycle mismatch; err_count=1; expected=6. Then feed 6 -> no pulse, miss_cnt cleared, still locked.
- Locked with expected=4, feed 0 -> restart pulse, no mismatch, err_count unchanged, expected=1. Then feed 7 (illegal) three times -> three mismatch pulses, err_count+3, locked=0 after the third, state HUNT.
- Toggle sample=0 for 5 cycles mid-sequence while value changes randomly -> expected, locked and err_count unchanged.
- Assert clear_stats in the same cycle as a mismatching sample with err_count=2 -> err_count=0, mismatch pulse still seen. Assert reset=0 mid-cycle while locked -> locked=0 and expected=0 immediately, before the next clock edge.

Source files
------------

// File: rtl/counter_seq_checker.sv
// Observer for a mod-MOD counter: locks onto the 0..MOD-1 wrap sequence and
// reports mismatches, counter restarts and a saturating error count.
module counter_seq_checker #(
    parameter int WIDTH    = 3,
    parameter int MOD      = 7,
    parameter int LOCK_LEN = 4,
    parameter int LOSS_LEN = 3
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             sample,
    input  logic [WIDTH-1:0] value,
    input  logic             clear_stats,
    output logic             locked,
    output logic             mismatch,
    output logic             restart,
    output logic [WIDTH-1:0] expected,
    output logic [7:0]       err_count
);

    localparam logic [1:0] ST_HUNT   = 2'd0;
    localparam logic [1:0] ST_VERIFY = 2'd1;
    localparam logic [1:0] ST_LOCKED = 2'd2;

    localparam int GW = (LOCK_LEN < 1) ? 1 : $clog2(LOCK_LEN + 1);
    localparam int LW = (LOSS_LEN < 1) ? 1 : $clog2(LOSS_LEN + 1);

    localparam logic [WIDTH-1:0] MOD_M1     = WIDTH'(MOD - 1);
    localparam logic [WIDTH:0]   MOD_W      = (WIDTH + 1)'(MOD);
    localparam logic [GW-1:0]    LOCK_LEN_C = GW'(LOCK_LEN);
    localparam logic [LW-1:0]    LOSS_LEN_C = LW'(LOSS_LEN);
    localparam logic [WIDTH-1:0] ZERO_V     = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0] ONE_V      = {{(WIDTH-1){1'b0}}, 1'b1};

    function automatic logic [WIDTH-1:0] next_val(input logic [WIDTH-1:0] v);
        if (v == MOD_M1) begin
            return ZERO_V;
        end else begin
            return v + ONE_V;
        end
    endfunction

    logic [1:0]       state_r,    state_s;
    logic [WIDTH-1:0] expected_r, expected_s;
    logic [GW-1:0]    good_cnt_r, good_cnt_s;
    logic [LW-1:0]    miss_cnt_r, miss_cnt_s;
    logic [7:0]       err_r,      err_s;
    logic             mismatch_r, mismatch_s;
    logic             restart_r,  restart_s;
    logic             locked_r;
    logic             legal_s;
    logic             err_inc_s;
    logic [GW-1:0]    good_inc_s;
    logic [LW-1:0]    miss_inc_s;

    assign legal_s    = ({1'b0, value} < MOD_W);
    assign good_inc_s = good_cnt_r + {{(GW-1){1'b0}}, 1'b1};
    assign miss_inc_s = miss_cnt_r + {{(LW-1){1'b0}}, 1'b1};

    // Next-state decode for the sequence tracker.
    always_comb begin
        state_s    = state_r;
        expected_s = expected_r;
        good_cnt_s = good_cnt_r;
        miss_cnt_s = miss_cnt_r;
        mismatch_s = 1'b0;
        restart_s  = 1'b0;
        err_inc_s  = 1'b0;
        if (sample) begin
            case (state_r)
                ST_HUNT: begin
                    if (value == ZERO_V) begin
                        state_s    = (LOCK_LEN_C == {{(GW-1){1'b0}}, 1'b1}) ? ST_LOCKED : ST_VERIFY;
                        expected_s = ONE_V;
                        good_cnt_s = {{(GW-1){1'b0}}, 1'b1};
                    end else begin
                        state_s = ST_HUNT;
                    end
                end
                ST_VERIFY: begin
                    if (value == expected_r) begin
                        expected_s = next_val(value);
                        good_cnt_s = good_inc_s;
                        if (good_inc_s == LOCK_LEN_C) begin
                            state_s = ST_LOCKED;
                        end else begin
                            state_s = ST_VERIFY;
                        end
                    end else if (value == ZERO_V) begin
                        expected_s = ONE_V;
                        good_cnt_s = {{(GW-1){1'b0}}, 1'b1};
                    end else begin
                        state_s    = ST_HUNT;
                        expected_s = ZERO_V;
                        good_cnt_s = {GW{1'b0}};
                    end
                end
                ST_LOCKED: begin
                    if (value == expected_r) begin
                        expected_s = next_val(value);
                        miss_cnt_s = {LW{1'b0}};
                    end else if (value == ZERO_V) begin
                        // Counter was reset underneath us: resync, not an error.
                        restart_s  = 1'b1;
                        expected_s = ONE_V;
                        miss_cnt_s = {LW{1'b0}};
                    end else begin
                        mismatch_s = 1'b1;
                        err_inc_s  = 1'b1;
                        expected_s = legal_s ? next_val(value) : next_val(expected_r);
                        if (miss_inc_s == LOSS_LEN_C) begin
                            state_s    = ST_HUNT;
                            expected_s = ZERO_V;
                            miss_cnt_s = {LW{1'b0}};
                            good_cnt_s = {GW{1'b0}};
                        end else begin
                            miss_cnt_s = miss_inc_s;
                        end
                    end
                end
                default: begin
                    state_s    = ST_HUNT;
                    expected_s = ZERO_V;
                    good_cnt_s = {GW{1'b0}};
                    miss_cnt_s = {LW{1'b0}};
                end
            endcase
        end else begin
            state_s = state_r;
        end
    end

    // Error counter: clear wins over a same-cycle increment, saturates at 255.
    always_comb begin
        err_s = err_r;
        if (clear_stats) begin
            err_s = 8'd0;
        end else if (err_inc_s && (err_r != 8'd255)) begin
            err_s = err_r + 8'd1;
        end else begin
            err_s = err_r;
        end
    end

    // State and output registers.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_r    <= ST_HUNT;
            expected_r <= ZERO_V;
            good_cnt_r <= {GW{1'b0}};
            miss_cnt_r <= {LW{1'b0}};
            err_r      <= 8'd0;
            mismatch_r <= 1'b0;
            restart_r  <= 1'b0;
            locked_r   <= 1'b0;
        end else begin
            state_r    <= state_s;
            expected_r <= expected_s;
            good_cnt_r <= good_cnt_s;
            miss_cnt_r <= miss_cnt_s;
            err_r      <= err_s;
            mismatch_r <= mismatch_s;
            restart_r  <= restart_s;
            locked_r   <= (state_s == ST_LOCKED);
        end
    end

    assign locked    = locked_r;
    assign mismatch  = mismatch_r;
    assign restart   = restart_r;
    assign expected  = expected_r;
    assign err_count = err_r;

endmodule

// File: tb/tb_counter_seq_checker.sv
// Directed bench for counter_seq_checker (WIDTH=3, MOD=7, LOCK_LEN=4, LOSS_LEN=3).
module tb_counter_seq_checker;

    logic       clock;
    logic       reset;
    logic       sample;
    logic [2:0] value;
    logic       clear_stats;
    logic       locked;
    logic       mismatch;
    logic       restart;
    logic [2:0] expected;
    logic [7:0] err_count;

    int n_checks;
    int n_fail;

    counter_seq_checker #(
        .WIDTH(3), .MOD(7), .LOCK_LEN(4), .LOSS_LEN(3)
    ) dut (
        .clock(clock), .reset(reset), .sample(sample), .value(value),
        .clear_stats(clear_stats), .locked(locked), .mismatch(mismatch),
        .restart(restart), .expected(expected), .err_count(err_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, want %0d", tag, obs, exp);
        end
    endtask

    // One sampled value; outputs are checked 1 time unit after the edge.
    task automatic feed(input logic [2:0] v);
        sample = 1'b1;
        value  = v;
        @(posedge clock);
        #1;
        sample = 1'b0;
    endtask

    task automatic idle(input int n);
        sample = 1'b0;
        for (int i = 0; i < n; i++) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic check_outs(input string tag, input logic l, input logic m, input logic r,
                              input logic [2:0] e, input logic [7:0] c);
        check_val({tag, ".locked"},   {31'd0, locked},   {31'd0, l});
        check_val({tag, ".mismatch"}, {31'd0, mismatch}, {31'd0, m});
        check_val({tag, ".restart"},  {31'd0, restart},  {31'd0, r});
        check_val({tag, ".expected"}, {29'd0, expected}, {29'd0, e});
        check_val({tag, ".err"},      {24'd0, err_count}, {24'd0, c});
    endtask

    logic [2:0] m_exp;
    logic [2:0] v_bad;
    int         m_err;

    initial begin
        n_checks    = 0;
        n_fail      = 0;
        reset       = 1'b0;
        sample      = 1'b0;
        value       = 3'd0;
        clear_stats = 1'b0;
        #12;
        check_outs("reset", 1'b0, 1'b0, 1'b0, 3'd0, 8'd0);
        @(posedge clock);
        #3;
        reset = 1'b1;
        #3;

        // Lock acquisition.
        feed(3'd0); check_outs("lock0", 1'b0, 1'b0, 1'b0, 3'd1, 8'd0);
        feed(3'd1); check_outs("lock1", 1'b0, 1'b0, 1'b0, 3'd2, 8'd0);
        feed(3'd2); check_outs("lock2", 1'b0, 1'b0, 1'b0, 3'd3, 8'd0);
        feed(3'd3); check_outs("lock3", 1'b1, 1'b0, 1'b0, 3'd4, 8'd0);

        // Clean run through the wrap.
        feed(3'd4); check_outs("run4", 1'b1, 1'b0, 1'b0, 3'd5, 8'd0);
        feed(3'd5); check_outs("run5", 1'b1, 1'b0, 1'b0, 3'd6, 8'd0);
        feed(3'd6); check_outs("run6", 1'b1, 1'b0, 1'b0, 3'd0, 8'd0);
        feed(3'd0); check_outs("wrap0", 1'b1, 1'b0, 1'b0, 3'd1, 8'd0);
        feed(3'd1); check_outs("run1", 1'b1, 1'b0, 1'b0, 3'd2, 8'd0);

        // Legal mismatch then recovery.
        feed(3'd5); check_outs("mis5", 1'b1, 1'b1, 1'b0, 3'd6, 8'd1);
        feed(3'd6); check_outs("rec6", 1'b1, 1'b0, 1'b0, 3'd0, 8'd1);
        feed(3'd0); feed(3'd1); feed(3'd2); feed(3'd3);
        check_outs("pre_restart", 1'b1, 1'b0, 1'b0, 3'd4, 8'd1);

        // Restart, then three illegal samples drop lock.
        feed(3'd0); check_outs("restart", 1'b1, 1'b0, 1'b1, 3'd1, 8'd1);
        feed(3'd7); check_outs("ill1", 1'b1, 1'b1, 1'b0, 3'd2, 8'd2);
        feed(3'd7); check_outs("ill2", 1'b1, 1'b1, 1'b0, 3'd3, 8'd3);
        feed(3'd7); check_outs("ill3", 1'b0, 1'b1, 1'b0, 3'd0, 8'd4);
        idle(1);    check_outs("pulse_end", 1'b0, 1'b0, 1'b0, 3'd0, 8'd4);

        // HUNT ignores non-zero values, then relock.
        feed(3'd3); check_outs("hunt3", 1'b0, 1'b0, 1'b0, 3'd0, 8'd4);
        feed(3'd0); feed(3'd1); feed(3'd2); feed(3'd3);
        check_outs("relock", 1'b1, 1'b0, 1'b0, 3'd4, 8'd4);

        // sample=0 freezes everything regardless of value.
        for (int i = 0; i < 5; i++) begin
            value = 3'($urandom_range(0, 7));
            @(posedge clock);
            #1;
            check_outs("hold", 1'b1, 1'b0, 1'b0, 3'd4, 8'd4);
        end
        feed(3'd4); check_outs("after_hold", 1'b1, 1'b0, 1'b0, 3'd5, 8'd4);

        // clear_stats with sample idle, then build err_count to 2.
        clear_stats = 1'b1;
        idle(1);
        clear_stats = 1'b0;
        check_outs("clr_idle", 1'b1, 1'b0, 1'b0, 3'd5, 8'd0);
        feed(3'd2); check_outs("e1", 1'b1, 1'b1, 1'b0, 3'd3, 8'd1);
        feed(3'd3); feed(3'd1); feed(3'd2);
        check_outs("e2", 1'b1, 1'b0, 1'b0, 3'd3, 8'd2);
        clear_stats = 1'b1;
        feed(3'd6);
        clear_stats = 1'b0;
        check_outs("clr_mis", 1'b1, 1'b1, 1'b0, 3'd0, 8'd0);

        // Saturation: alternate mismatch and correct samples.
        m_exp = 3'd0;
        m_err = 0;
        for (int i = 0; i < 260; i++) begin
            v_bad = (m_exp == 3'd5) ? 3'd1 : ((m_exp == 3'd6) ? 3'd1 : m_exp + 3'd2);
            feed(v_bad);
            m_err = (m_err < 255) ? m_err + 1 : 255;
            m_exp = (v_bad == 3'd6) ? 3'd0 : v_bad + 3'd1;
            check_val("sat.err", {24'd0, err_count}, m_err);
            feed(m_exp);
            m_exp = (m_exp == 3'd6) ? 3'd0 : m_exp + 3'd1;
        end
        check_val("sat.final", {24'd0, err_count}, 32'd255);
        v_bad = (m_exp == 3'd5 || m_exp == 3'd6) ? 3'd1 : m_exp + 3'd2;
        feed(v_bad);
        check_outs("sat.pulse", 1'b1, 1'b1, 1'b0, (v_bad == 3'd6) ? 3'd0 : v_bad + 3'd1, 8'd255);

        // Asynchronous reset mid-cycle while locked.
        #2;
        reset = 1'b0;
        #2;
        check_outs("async_rst", 1'b0, 1'b0, 1'b0, 3'd0, 8'd0);
        #3;
        reset = 1'b1;
        @(posedge clock);
        #1;

        // VERIFY: restart on 0, then non-zero mismatch returns to HUNT.
        feed(3'd0); feed(3'd1);
        feed(3'd0); check_outs("ver_restart", 1'b0, 1'b0, 1'b0, 3'd1, 8'd0);
        feed(3'd1); feed(3'd2);
        feed(3'd5); check_outs("ver_fail", 1'b0, 1'b0, 1'b0, 3'd0, 8'd0);
        feed(3'd1); check_outs("ver_hunt", 1'b0, 1'b0, 1'b0, 3'd0, 8'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
